// File: rtl/psum_accum_buffer.sv
// Pipelined read-modify-write partial-sum buffer with a separate drain (readout) port.
// Build option: define PSUM_SAT_EN to saturate accumulates on signed overflow; otherwise they wrap.
module psum_accum_buffer #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 13,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_first,
  input  logic              out_req,
  output logic              out_ack,
  input  logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  // Registered stages: R1..R(RD_LAT) then W; stage A is the accept cycle itself.
  localparam int STAGES = RD_LAT + 1;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct packed {
    logic              first;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  logic [STAGES:1]   vld_pipe_q, vld_pipe_d;
  logic [RD_LAT:1]   ro_pipe_q, ro_pipe_d;
  logic              run_q;
  req_t              req_pipe_q [1:STAGES];
  logic [DATA_W-1:0] rd_q [1:RD_LAT];
  logic [DATA_W-1:0] old_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              hazard, pipe_busy, ro_busy, acc_go;
  logic [ADDR_W-1:0] rd_addr;
  req_t              wr_req;
  logic [DATA_W-1:0] wr_data;

  // No forwarding: a request waits until every older write to its word has landed.
  always_comb begin
    hazard = 1'b0;
    for (int k = 1; k <= STAGES; k++)
      if (vld_pipe_q[k] && req_pipe_q[k].addr == in_addr) hazard = 1'b1;
  end

  assign pipe_busy = |vld_pipe_q;
  assign ro_busy   = |ro_pipe_q;
  assign in_ready  = run_q && !out_req && !hazard;
  assign out_ack   = run_q && out_req && !pipe_busy && !ro_busy;
  assign acc_go    = in_valid && in_ready;
  assign rd_addr   = out_req ? out_addr : in_addr;
  assign busy      = pipe_busy | ro_busy;

  always_comb begin
    vld_pipe_d    = '0;
    ro_pipe_d     = '0;
    vld_pipe_d[1] = acc_go;
    ro_pipe_d[1]  = out_ack;
    for (int k = 2; k <= STAGES; k++) vld_pipe_d[k] = vld_pipe_q[k-1];
    for (int k = 2; k <= RD_LAT; k++) ro_pipe_d[k]  = ro_pipe_q[k-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      ro_pipe_q  <= '0;
      run_q      <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      ro_pipe_q  <= ro_pipe_d;
      run_q      <= 1'b1;
    end
  end

  // Payload travels unreset; only the valid bits qualify it.
  always_ff @(posedge clk) begin
    req_pipe_q[1] <= req_t'{in_first, in_addr, in_data};
    for (int k = 2; k <= STAGES; k++) req_pipe_q[k] <= req_pipe_q[k-1];
    old_q <= rd_q[RD_LAT];
  end

  assign wr_req = req_pipe_q[STAGES];

`ifdef PSUM_SAT_EN
  logic [DATA_W:0] sum_ext;
  always_comb begin
    sum_ext = {old_q[DATA_W-1], old_q} + {wr_req.data[DATA_W-1], wr_req.data};
    if (wr_req.first)
      wr_data = wr_req.data;
    else if (sum_ext[DATA_W] != sum_ext[DATA_W-1])
      wr_data = sum_ext[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      wr_data = sum_ext[DATA_W-1:0];
  end
`else
  always_comb begin
    wr_data = wr_req.first ? wr_req.data : old_q + wr_req.data;
  end
`endif

  // Simple dual-port RAM: one write (W stage), one read with RD_LAT register stages.
  always_ff @(posedge clk) begin
    if (vld_pipe_q[STAGES]) mem_q[wr_req.addr] <= wr_data;
    rd_q[1] <= mem_q[rd_addr];
    for (int k = 2; k <= RD_LAT; k++) rd_q[k] <= rd_q[k-1];
  end

  assign out_valid = ro_pipe_q[RD_LAT];
  assign out_data  = out_valid ? rd_q[RD_LAT] : '0;

endmodule
